// File: rtl/denise_scandoubler.sv
// Line doubler behind Denise: captures each 15 kHz line into one half of a
// ping-pong buffer while the other half is replayed twice at the 28 MHz rate.
module denise_scandoubler #(
    parameter int DEPTH = 1024,
    parameter int HSW   = 64
) (
    input  logic       C28M,
    input  logic       nRESET,
    input  logic       PIX_EN,
    input  logic [3:0] RED,
    input  logic [3:0] GREEN,
    input  logic [3:0] BLUE,
    input  logic       nZD,
    input  logic       nCBL,
    input  logic       nHSYNC_IN,
    input  logic       nVSYNC_IN,
    output logic [3:0] VGA_R,
    output logic [3:0] VGA_G,
    output logic [3:0] VGA_B,
    output logic       nZD_OUT,
    output logic       nBLANK_OUT,
    output logic       nHSYNC_OUT,
    output logic       nVSYNC_OUT,
    output logic       OVF
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [31:0] HSW_W = 32'(HSW);

    typedef enum logic [1:0] {IDLE, PASS0, PASS1} rdStateT;

    // Both banks share one array; the top address bit selects the bank.
    logic [13:0]   lineMem [0:2*DEPTH-1];
    logic [13:0]   ramQ;

    logic          hsPrev;
    logic          wrBank;
    logic [AW:0]   wrAddr;
    logic [AW:0]   lineLen;
    logic          synced;
    logic          vsLine;
    logic          vsDisp;
    logic          ovfReg;

    rdStateT       state;
    rdStateT       stateNext;
    logic [AW-1:0] rdAddr;
    logic [AW-1:0] rdAddrNext;

    logic          p1Valid;
    logic          p1Hs;
    logic          p1Vs;

    logic          lineEdge;
    logic          wrEn;
    logic          lastAddr;
    logic [AW:0]   wrIdx;
    logic [AW:0]   rdIdx;

    assign lineEdge = PIX_EN & hsPrev & ~nHSYNC_IN;
    // wrAddr never exceeds DEPTH, so its top bit alone flags a full bank.
    assign wrEn     = PIX_EN & (lineEdge | (synced & ~wrAddr[AW]));
    assign wrIdx    = lineEdge ? {~wrBank, {AW{1'b0}}} : {wrBank, wrAddr[AW-1:0]};
    assign rdIdx    = {~wrBank, rdAddr};
    assign lastAddr = ({1'b0, rdAddr} == (lineLen - 1'b1));
    assign OVF      = ovfReg;

    always_ff @(posedge C28M) begin
        if (wrEn) begin
            lineMem[wrIdx] <= {nCBL, nZD, RED, GREEN, BLUE};
        end
        ramQ <= lineMem[rdIdx];
    end

    // Pixels are only stored once a line edge has been seen after reset, so a
    // partial line never reaches the replay side.
    always_ff @(posedge C28M) begin
        if (!nRESET) begin
            hsPrev  <= 1'b1;
            wrBank  <= 1'b0;
            wrAddr  <= '0;
            lineLen <= '0;
            synced  <= 1'b0;
            vsLine  <= 1'b1;
            vsDisp  <= 1'b1;
            ovfReg  <= 1'b0;
        end else if (PIX_EN) begin
            hsPrev <= nHSYNC_IN;
            if (lineEdge) begin
                lineLen <= wrAddr;
                wrBank  <= ~wrBank;
                wrAddr  <= (AW+1)'(1);
                synced  <= 1'b1;
                vsLine  <= nVSYNC_IN;
                vsDisp  <= vsLine;
            end else if (synced) begin
                if (!wrAddr[AW]) begin
                    wrAddr <= wrAddr + 1'b1;
                end else begin
                    ovfReg <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge C28M) begin
        if (!nRESET) begin
            state  <= IDLE;
            rdAddr <= '0;
        end else begin
            state  <= stateNext;
            rdAddr <= rdAddrNext;
        end
    end

    always_comb begin
        stateNext  = state;
        rdAddrNext = rdAddr;
        if (lineEdge) begin
            rdAddrNext = '0;
            stateNext  = (wrAddr != '0) ? PASS0 : IDLE;
        end else begin
            case (state)
                PASS0: begin
                    if (lastAddr) begin
                        stateNext  = PASS1;
                        rdAddrNext = '0;
                    end else begin
                        rdAddrNext = rdAddr + 1'b1;
                    end
                end
                PASS1: begin
                    if (lastAddr) begin
                        stateNext  = IDLE;
                        rdAddrNext = '0;
                    end else begin
                        rdAddrNext = rdAddr + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Stage 1 tracks the RAM read; stage 2 is the output register.
    always_ff @(posedge C28M) begin
        if (!nRESET) begin
            p1Valid    <= 1'b0;
            p1Hs       <= 1'b1;
            p1Vs       <= 1'b1;
            VGA_R      <= 4'h0;
            VGA_G      <= 4'h0;
            VGA_B      <= 4'h0;
            nZD_OUT    <= 1'b1;
            nBLANK_OUT <= 1'b0;
            nHSYNC_OUT <= 1'b1;
            nVSYNC_OUT <= 1'b1;
        end else begin
            p1Valid <= (state != IDLE);
            p1Hs    <= ({{(32-AW){1'b0}}, rdAddr} >= HSW_W);
            p1Vs    <= vsDisp;
            if (p1Valid) begin
                {VGA_R, VGA_G, VGA_B} <= ramQ[13] ? ramQ[11:0] : 12'h000;
                nZD_OUT    <= ramQ[12];
                nBLANK_OUT <= ramQ[13];
                nHSYNC_OUT <= p1Hs;
                nVSYNC_OUT <= p1Vs;
            end else begin
                {VGA_R, VGA_G, VGA_B} <= 12'h000;
                nZD_OUT    <= 1'b1;
                nBLANK_OUT <= 1'b0;
                nHSYNC_OUT <= 1'b1;
            end
        end
    end
endmodule

// File: doc/denise_scandoubler.md
# denise_scandoubler

Line-doubling stage directly downstream of the Denise video output. It captures the 15 kHz RGB444 pixel stream together with nZD and nCBL into a ping-pong line buffer, then replays each completed line twice at double rate, producing 31 kHz RGB plus regenerated sync for a VGA-class monitor. Its capture side runs from Denise's 14 MHz pixel strobe; its replay side runs every cycle of the 28 MHz master clock.

## Interface
Parameters:
- DEPTH, 1024: line buffer entries per bank (power of two; AW = log2(DEPTH)).
- HSW, 64: output horizontal sync width in C28M cycles.

Ports:
- C28M  in  1  master clock, 28 MHz; all logic on rising edge.
- nRESET  in  1  reset, synchronous, active-low.
- PIX_EN  in  1  pixel strobe, high one C28M cycle in two (14 MHz pixel rate).
- RED, GREEN, BLUE  in  4 each  Denise pixel colour, valid when PIX_EN=1.
- nZD  in  1  Denise background indicator, valid when PIX_EN=1.
- nCBL  in  1  composite blank, active-low, valid when PIX_EN=1.
- nHSYNC_IN  in  1  input horizontal sync, active-low.
- nVSYNC_IN  in  1  input vertical sync, active-low.
- VGA_R, VGA_G, VGA_B  out  4 each  doubled pixel colour.
- nZD_OUT  out  1  doubled background indicator.
- nBLANK_OUT  out  1  active-low blank.
- nHSYNC_OUT  out  1  regenerated 31 kHz horizontal sync, active-low.
- nVSYNC_OUT  out  1  delayed vertical sync, active-low.
- OVF  out  1  sticky flag: an input line exceeded DEPTH pixels.

## Operation
- Storage: two banks of DEPTH x 14 bits, entry = {nCBL, nZD, R, G, B}. One synchronous-read port serves the read side; one write port serves the write side.
- Write side, active only on PIX_EN=1 cycles:
  - Sample nHSYNC_IN each strobe. A line edge is previous sample 1 and current sample 0.
  - On a line edge: line_len <= wr_addr, wr_bank toggles, current pixel is written to address 0 of the new bank, wr_addr <= 1, read side restarts.
  - Otherwise: if wr_addr < DEPTH, write the pixel and increment wr_addr. If wr_addr = DEPTH, drop the pixel, hold wr_addr and set OVF. OVF clears only on reset.
- Read side reads bank ~wr_bank. States and transitions:
  - IDLE: outputs blanked. Go to PASS0 on a line edge with line_len > 0. If line_len = 0, stay in IDLE.
  - PASS0: rd_addr runs 0..line_len-1, one address per C28M cycle. Go to PASS1 after the last address, with no gap.
  - PASS1: same address sequence. After the last address, go to IDLE.
  - A line edge in any state aborts the current pass. The read side reloads to PASS0 at address 0 of the newly completed bank.
- Horizontal sync: nHSYNC_OUT is low for the first min(HSW, line_len) output cycles of each pass, high otherwise.
- Vertical sync: at each line edge, vs_line <= nVSYNC_IN and vs_disp <= vs_line. nVSYNC_OUT takes vs_disp aligned with the first pixel of PASS0 and holds through PASS1. It therefore carries the vsync sampled at the edge that began the line now displayed.
- Blanking:
  - nBLANK_OUT = stored nCBL in PASS0/PASS1.
  - In IDLE: nBLANK_OUT=0, RGB=0, nZD_OUT=1, nHSYNC_OUT=1.
  - Blanked pixels (stored nCBL=0) output RGB 0.

## Timing
- Reset values: VGA_R/G/B=0, nZD_OUT=1, nBLANK_OUT=0, nHSYNC_OUT=1, nVSYNC_OUT=1, OVF=0. Internal reset: state IDLE, wr_bank 0, wr_addr 0, line_len 0, vs_line=vs_disp=1, previous hsync sample 1.
- Reset asserted mid-line forces all of the above on the next edge. The line in progress is discarded.
- Latency: with a line edge registered at edge t, RAM address 0 is presented after t+1. The first pixel and the nHSYNC_OUT fall appear on outputs after edge t+2.
- Pass length: each pass is exactly line_len cycles. The output line period is therefore half the input period when the input is steady.
- Read/write overlap: never on the same bank. The write bank toggles on the same edge that the read bank is selected.

## Test plan
- Steady input: 908-pixel lines, pixel i colour = i mod 4096, HSW=64. Required: each line output twice, 908 cycles per pass; nHSYNC_OUT low 64 cycles per pass; pixel 0 appears 2 cycles after the edge.
- Overflow: DEPTH=1024, one 1100-pixel line. Required: OVF=1 from pixel 1024 onward and stays 1; the replay pass is 1024 cycles long; the next normal 908-pixel line replays correctly.
- Short line: line edges 10 strobes apart, HSW=64. Required: nHSYNC_OUT low for the full 10 cycles of each pass; IDLE blanking after PASS1 until the next edge.
- Abort: line edge arrives while in PASS1 at address 200. Required: next output pixel (2 cycles later) is address 0 of the new bank with nHSYNC_OUT falling; no stale pixel appears.
- Vsync and blank: nVSYNC_IN low across 3 line edges, nCBL low on pixels 0..99. Required: nVSYNC_OUT low for 3 output line pairs, delayed one input line; nBLANK_OUT=0 and RGB=0 for output cycles 0..99 of both passes.
- Reset mid-pass: nRESET low for 1 cycle during PASS0. Required: all outputs at reset values on the next edge; no output until two further line edges have been seen.
